// File: rtl/cpu_io_pkg.sv
// ---------------------------------------------------------------------------
// cpu_io_pkg
// Shared constants for the cpu_top external I/O port pair. The word width is
// used by the cpu_top wrapper, the I/O bridge and its bench so that all three
// agree on the size of x2/y2.
// ---------------------------------------------------------------------------
package cpu_io_pkg;

    // Width of the cpu_top x2/y2 data words.
    localparam int DATA_W = 30;

    // Default number of CPU->host FIFO entries (power of two, at least 2).
    localparam int FIFO_DEPTH = 4;

    // Occupancy counter width for a FIFO of the given depth: holds 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and no fall-through: a word
// written in one cycle appears at the head the following cycle. Requests are
// qualified internally, so a push while full or a pop while empty is ignored.
//
// Ports
//   clk      in   1       rising-edge clock
//   rst      in   1       asynchronous active-high reset (pointers/count only)
//   push_req in   1       write wr_data if not full
//   wr_data  in   DATA_W  word to write
//   pop_req  in   1       advance head if not empty
//   rd_data  out  DATA_W  head word (meaningful when !empty)
//   count    out  CNT_W   occupancy 0..DEPTH
//   full     out  1       count == DEPTH
//   empty    out  1       count == 0
// ---------------------------------------------------------------------------
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = cpu_io_pkg::DATA_W,
    parameter int DEPTH  = cpu_io_pkg::FIFO_DEPTH,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop_req,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Status comes straight from the registered count, so a pop in the same
    // cycle as full does not reopen the write side until the next cycle.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = push_req && !full;
    assign pop   = pop_req && !empty;

    // Head word is a plain read of the storage array at the read pointer.
    assign rd_data = mem[rd_ptr];

    // Storage array is deliberately left out of reset; only the pointers and
    // count define which entries hold live data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The count only
    // moves when exactly one of push/pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// ---------------------------------------------------------------------------
// cpu_io_bridge
// External-side endpoint for cpu_top's x/y I/O ports. Words the CPU emits on
// y2 (strobed by y1) are buffered for a host reader; the host loads a mailbox
// word that the CPU sees on x2. x1 tells the CPU whether the buffer has room.
//
// Ports
//   clk, rst       clock / asynchronous active-high reset
//   cpu_y1, cpu_y2 CPU push strobe and data word
//   cpu_x1         ready to CPU (buffer not full)
//   cpu_x2         registered mailbox word to CPU
//   host_rd_valid  buffer non-empty
//   host_rd_data   buffer head word
//   host_rd_pop    consume head word
//   host_wr_en     load mailbox with host_wr_data
//   host_clr_ovf   clear sticky overflow flag
//   fifo_count     buffer occupancy
//   ovf            sticky: CPU strobed a word while not ready
// ---------------------------------------------------------------------------
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = cpu_io_pkg::DATA_W,
    parameter int DEPTH  = cpu_io_pkg::FIFO_DEPTH,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_y1,
    input  logic [DATA_W-1:0] cpu_y2,
    output logic              cpu_x1,
    output logic [DATA_W-1:0] cpu_x2,
    output logic              host_rd_valid,
    output logic [DATA_W-1:0] host_rd_data,
    input  logic              host_rd_pop,
    input  logic              host_wr_en,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_clr_ovf,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              ovf
);

    logic full;
    logic empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (cpu_y1),
        .wr_data  (cpu_y2),
        .pop_req  (host_rd_pop),
        .rd_data  (host_rd_data),
        .count    (fifo_count),
        .full     (full),
        .empty    (empty)
    );

    assign cpu_x1        = !full;
    assign host_rd_valid = !empty;

    // Mailbox word presented to the CPU; changes only on a host write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_x2 <= '0;
        end else if (host_wr_en) begin
            cpu_x2 <= host_wr_data;
        end
    end

    // Sticky overflow: a dropped word sets it, and setting takes priority over
    // a host clear arriving in the same cycle so no drop goes unnoticed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (cpu_y1 && full) begin
            ovf <= 1'b1;
        end else if (host_clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule
